// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem burst responder and its line store.
package pmem_pkg;

    localparam int LINE_OFFSET_W  = 5;
    localparam int BYTES_PER_LINE = 32;
    localparam int PMEM_BEAT_W    = 64;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} pmem_state_e;
    typedef enum logic {OP_READ, OP_WRITE} pmem_op_e;
    typedef logic [PMEM_BEAT_W-1:0] pmem_beat_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmem_burst_responder_if.sv
// Physical-memory burst bus: requester (master) drives read/write/address/wdata,
// responder (slave) drives rdata/resp and the protocol-error flag.
interface pmem_burst_responder_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64
);
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              proto_err;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, proto_err
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, proto_err
    );
endinterface

// File: rtl/pmem_line_store.sv
// Beat-addressed single-port storage: synchronous write, registered read that
// only updates when re is high so the output holds its last beat.
module pmem_line_store #(
    parameter int AW     = 10,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [BEAT_W-1:0] wdata,
    output logic [BEAT_W-1:0] rdata
);
    localparam int WORDS = 1 << AW;

    logic [BEAT_W-1:0] mem [WORDS];
    logic [BEAT_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[addr];
    end

    // Array contents are deliberately outside reset: a reset only aborts traffic.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pmem_burst_responder.sv
// Line-burst memory responder: fixed-latency, BURST_LEN beats per 32-byte line.
// Optional protocol checker enabled by defining PMEM_PROTOCOL_CHECK_EN.
module pmem_burst_responder import pmem_pkg::*; #(
    parameter int ADDR_W      = 32,
    parameter int BEAT_W      = 64,
    parameter int BURST_LEN   = 4,
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 256
) (
    input logic                  clk,
    input logic                  rst,
    pmem_burst_responder_if.slave bus
);
    localparam int LINE_W     = cnt_w(DEPTH_LINES);
    localparam int BEAT_CNT_W = cnt_w(BURST_LEN);
    localparam int WAIT_CNT_W = $clog2(LATENCY + 1);
    localparam int AW         = LINE_W + BEAT_CNT_W;
    // WAIT is entered with LATENCY-2 so the last WAIT cycle presents beat 0 to the store.
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        (LATENCY >= 2) ? WAIT_CNT_W'(LATENCY - 2) : '0;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_LEN - 1);

    pmem_state_e             state_q, state_d;
    pmem_op_e                op_q, op_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
    logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
    logic                    resp_q, resp_d;
    logic                    req;

    assign req = bus.pmem_read | bus.pmem_write;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        line_d  = line_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: if (req) begin
                op_d    = bus.pmem_read ? OP_READ : OP_WRITE;
                line_d  = bus.pmem_address[LINE_OFFSET_W +: LINE_W];
                beat_d  = '0;
                wait_d  = WAIT_INIT;
                state_d = (LATENCY == 1) ? BURST : WAIT;
            end
            WAIT: begin
                if (wait_q == '0) state_d = BURST;
                else              wait_d  = wait_q - 1'b1;
            end
            BURST: begin
                if (beat_q == LAST_BEAT) state_d = DONE;
                else                     beat_d  = beat_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign resp_d = (state_d == BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            line_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            line_q  <= line_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            resp_q  <= resp_d;
        end
    end

    // Reads look one beat ahead so registered data lines up with resp;
    // writes use the current beat.
    logic          st_we, st_re;
    logic [AW-1:0] st_addr;

    assign st_we   = (state_q == BURST) && (op_q == OP_WRITE);
    assign st_re   = resp_d && (op_d == OP_READ);
    assign st_addr = st_we ? {line_q, beat_q} : {line_d, beat_d};

    pmem_line_store #(.AW(AW), .BEAT_W(BEAT_W)) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (st_we),
        .re    (st_re),
        .addr  (st_addr),
        .wdata (bus.pmem_wdata),
        .rdata (bus.pmem_rdata)
    );

    assign bus.pmem_resp = resp_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              perr_q, perr_d;
    logic              busy, held;

    always_comb begin
        addr_d = addr_q;
        perr_d = perr_q;
        busy   = (state_q == WAIT) || (state_q == BURST);
        held   = (op_q == OP_READ) ? bus.pmem_read : bus.pmem_write;
        if (state_q == IDLE && req) begin
            addr_d = bus.pmem_address;
            if ((bus.pmem_read && bus.pmem_write) ||
                (bus.pmem_address[LINE_OFFSET_W-1:0] != '0))
                perr_d = 1'b1;
        end
        if (busy && (!held || (bus.pmem_address != addr_q))) perr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            perr_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            perr_q <= perr_d;
        end
    end

    assign bus.proto_err = perr_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pmem_address[ADDR_W-1:LINE_OFFSET_W+LINE_W],
                                bus.pmem_address[LINE_OFFSET_W-1:0]};
    assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed + randomized bench for pmem_burst_responder (LATENCY 10 and LATENCY 1 instances)
// against a line/beat array model with cycle-exact response timing.
module tb_pmem_burst_responder;
    import pmem_pkg::*;

    localparam int LAT = 10;
    localparam int BL  = 4;
    localparam int DL  = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pmem_burst_responder_if #(.ADDR_W(32), .BEAT_W(64)) bus0 ();
    pmem_burst_responder_if #(.ADDR_W(32), .BEAT_W(64)) bus1 ();

    pmem_burst_responder #(.ADDR_W(32), .BEAT_W(64), .BURST_LEN(BL), .LATENCY(LAT),
                           .DEPTH_LINES(DL)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pmem_burst_responder #(.ADDR_W(32), .BEAT_W(64), .BURST_LEN(BL), .LATENCY(1),
                           .DEPTH_LINES(DL)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int         checks = 0;
    int         errors = 0;
    int         sel = 0;
    pmem_beat_t mem_m [2][DL*BL];
    bit         perr_m [2];
    int         pool [2][6];

    logic        o_resp, o_perr;
    logic [63:0] o_rdata;
    assign o_resp  = (sel != 0) ? bus1.pmem_resp  : bus0.pmem_resp;
    assign o_rdata = (sel != 0) ? bus1.pmem_rdata : bus0.pmem_rdata;
    assign o_perr  = (sel != 0) ? bus1.proto_err  : bus0.proto_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, sel, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] a, input int beat);
        return int'((a / BYTES_PER_LINE) % DL) * BL + beat;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [63:0] wd);
        if (sel == 0) begin
            bus0.pmem_read = rd; bus0.pmem_write = wr; bus0.pmem_address = a; bus0.pmem_wdata = wd;
        end else begin
            bus1.pmem_read = rd; bus1.pmem_write = wr; bus1.pmem_address = a; bus1.pmem_wdata = wd;
        end
    endtask

    // One request on the selected DUT. Checks resp on every cycle from T+1 to the
    // DONE cycle, read data per beat, and proto_err at the end.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input bit fixed, input int abort_beat, input bit hold);
        int          lat;
        int          b;
        logic [63:0] wd;
        lat = (sel == 0) ? LAT : 1;
`ifdef PMEM_PROTOCOL_CHECK_EN
        if ((rd && wr) || (a[4:0] != 5'd0)) perr_m[sel] = 1'b1;
`endif
        @(negedge clk);
        drive(rd, wr, a, '0);
        for (int c = 1; c <= lat + BL; c++) begin
            @(negedge clk);
            chk("resp", o_resp, (c >= lat && c < lat + BL));
            if (c >= lat && c < lat + BL) begin
                b = c - lat;
                if (rd) begin
                    chk("rdata", o_rdata, mem_m[sel][idx(a, b)]);
                end else begin
                    wd = fixed ? 64'h1111111111111111 * 64'(b + 1) : {$urandom, $urandom};
                    drive(rd, wr, a, wd);
                    mem_m[sel][idx(a, b)] = wd;
                end
                if (b == abort_beat) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("abort_resp", o_resp, 1'b0);
                    chk("abort_rdata", o_rdata, 64'd0);
                    chk("abort_perr", o_perr, 1'b0);
                    perr_m[0] = 1'b0;
                    perr_m[1] = 1'b0;
                    rst = 1'b0;
                    drive(1'b0, 1'b0, '0, '0);
                    return;
                end
            end
        end
        if (rd) chk("rdata_hold", o_rdata, mem_m[sel][idx(a, BL-1)]);
        chk("proto_err", o_perr, perr_m[sel]);
        if (!hold) drive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        perr_m[0] = 1'b0;
        perr_m[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            drive(1'b0, 1'b0, '0, '0);
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk("rst_resp", o_resp, 1'b0);
            chk("rst_rdata", o_rdata, 64'd0);
            chk("rst_perr", o_perr, 1'b0);
        end
        rst = 1'b0;

        // Fixed-pattern write then readback, both latencies
        for (int s = 0; s < 2; s++) begin
            sel = s;
            do_req(1'b0, 1'b1, 32'h100, 1'b1, -1, 1'b0);
            do_req(1'b1, 1'b0, 32'h100, 1'b0, -1, 1'b0);
        end
        sel = 0;
        chk("pattern_beat3", mem_m[0][idx(32'h100, 3)], 64'h4444444444444444);

        // Request held through DONE must be served exactly once more, later
        do_req(1'b1, 1'b0, 32'h100, 1'b0, -1, 1'b1);
        do_req(1'b1, 1'b0, 32'h100, 1'b0, -1, 1'b0);

        // Aliasing and ignored offset bits
        do_req(1'b0, 1'b1, 32'h2020, 1'b0, -1, 1'b0);
        do_req(1'b1, 1'b0, 32'h0020, 1'b0, -1, 1'b0);
        do_req(1'b0, 1'b1, 32'h1000, 1'b0, -1, 1'b0);
        do_req(1'b1, 1'b0, 32'h101F, 1'b0, -1, 1'b0);

        // Reset on the second write beat: beats 0-1 new, 2-3 keep the pattern
        do_req(1'b0, 1'b1, 32'h100, 1'b0, 1, 1'b0);
        do_req(1'b1, 1'b0, 32'h100, 1'b0, -1, 1'b0);
        chk("partial_beat2", mem_m[0][idx(32'h100, 2)], 64'h3333333333333333);

        // Read and write together: read wins, flag is sticky until reset
        do_req(1'b1, 1'b1, 32'h100, 1'b0, -1, 1'b0);
        do_req(1'b1, 1'b0, 32'h2020, 1'b0, -1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        perr_m[0] = 1'b0;
        perr_m[1] = 1'b0;
        chk("perr_cleared", o_perr, 1'b0);

        // Randomized traffic over a small line pool with aliased upper bits
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int p = 0; p < 6; p++) begin
                pool[s][p] = int'($urandom_range(0, DL - 1));
                do_req(1'b0, 1'b1, 32'(pool[s][p]) << 5, 1'b0, -1, 1'b0);
            end
        end
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 1));
            a = (32'($urandom_range(0, 7)) << 13) | (32'(pool[sel][$urandom_range(0, 5)]) << 5);
            if ($urandom_range(0, 1) == 0) do_req(1'b1, 1'b0, a, 1'b0, -1, 1'b0);
            else                           do_req(1'b0, 1'b1, a, 1'b0, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
